// File: rtl/logic_gate_bank.sv
// Eight single-function gate lanes over a 16-bit operand word, with an optional
// output register. Each lane is its own module instance so it can be probed alone.

module lgb_and2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

module lgb_or2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i | b_i;
endmodule

module lgb_nand2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = ~(a_i & b_i);
endmodule

module lgb_nor2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = ~(a_i | b_i);
endmodule

module lgb_xor2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i ^ b_i;
endmodule

module lgb_xnor2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = ~(a_i ^ b_i);
endmodule

module lgb_inhibit2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & ~b_i;
endmodule

module lgb_not1 (
    input  logic a_i,
    output logic y_o
);
    assign y_o = ~a_i;
endmodule

module logic_gate_bank #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IN,
    output logic [7:0]  O
);
    logic [7:0] gate_s;

    lgb_and2     u_lane0 (.a_i(IN[0]),  .b_i(IN[1]),  .y_o(gate_s[0]));
    lgb_or2      u_lane1 (.a_i(IN[2]),  .b_i(IN[3]),  .y_o(gate_s[1]));
    lgb_nand2    u_lane2 (.a_i(IN[4]),  .b_i(IN[5]),  .y_o(gate_s[2]));
    lgb_nor2     u_lane3 (.a_i(IN[6]),  .b_i(IN[7]),  .y_o(gate_s[3]));
    lgb_xor2     u_lane4 (.a_i(IN[8]),  .b_i(IN[9]),  .y_o(gate_s[4]));
    lgb_xnor2    u_lane5 (.a_i(IN[10]), .b_i(IN[11]), .y_o(gate_s[5]));
    lgb_inhibit2 u_lane6 (.a_i(IN[12]), .b_i(IN[13]), .y_o(gate_s[6]));
    lgb_not1     u_lane7 (.a_i(IN[14]), .y_o(gate_s[7]));

    // IN[15] is reserved and intentionally left unconnected.
    logic unused_s;
    assign unused_s = IN[15];

    generate
        if (REG_OUT) begin : g_reg
            logic [7:0] o_d;
            logic [7:0] o_q;

            // Next-state: reset wins over the gate results.
            always_comb begin
                o_d = 8'h00;
                if (rst) begin
                    o_d = 8'h00;
                end else begin
                    o_d = gate_s;
                end
            end

            // Output register.
            always_ff @(posedge clk) begin
                o_q <= o_d;
            end

            assign O = o_q;
        end else begin : g_comb
            logic unused_clk_s;
            assign unused_clk_s = clk ^ rst;
            assign O = gate_s;
        end
    endgenerate
endmodule

// File: tb/tb_logic_gate_bank.sv
// Randomised self-checking bench for logic_gate_bank (REG_OUT=1) against a
// per-lane truth model built from operand counts.
`timescale 1ns/1ps

module tb_logic_gate_bank;
    logic        clk;
    logic        rst;
    logic [15:0] IN;
    logic [7:0]  O;

    int checks_cnt;
    int fail_cnt;

    logic_gate_bank #(.REG_OUT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .IN  (IN),
        .O   (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            fail_cnt++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, obs, exp_v);
        end
    endtask

    // Reference: each lane decided by how many of its two operands are high.
    function automatic logic [7:0] model(input logic [15:0] w);
        logic [7:0] r;
        int ones;
        r = 8'h00;
        for (int k = 0; k < 7; k++) begin
            ones = int'(w[2*k]) + int'(w[2*k+1]);
            case (k)
                0: r[k] = (ones == 2);
                1: r[k] = (ones >= 1);
                2: r[k] = (ones != 2);
                3: r[k] = (ones == 0);
                4: r[k] = (ones == 1);
                5: r[k] = (ones != 1);
                6: r[k] = (w[2*k] == 1'b1) && (w[2*k+1] == 1'b0);
                default: r[k] = 1'b0;
            endcase
        end
        r[7] = (w[14] == 1'b0);
        return r;
    endfunction

    task automatic step(input logic r_v, input logic [15:0] in_v);
        rst = r_v;
        IN  = in_v;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] o_ffff;
    logic [15:0] rin;
    logic rrst;

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst = 1'b1;
        IN  = 16'hFFFF;
        @(negedge clk);

        step(1'b1, 16'hFFFF); chk("reset_edge1", O, 8'h00);
        step(1'b1, 16'hFFFF); chk("reset_edge2", O, 8'h00);
        step(1'b0, 16'hFFFF); chk("post_reset_ffff", O, 8'h23);

        step(1'b0, 16'h0000); chk("in_0000", O, 8'hAC);
        step(1'b0, 16'h2AAA); chk("in_2aaa", O, 8'h96);
        step(1'b0, 16'h5555); chk("in_5555", O, 8'h56);
        step(1'b0, 16'hFFFF); chk("in_ffff", O, 8'h23);
        o_ffff = O;
        step(1'b0, 16'h7FFF); chk("in15_ignored", O, o_ffff);
        step(1'b0, 16'h3FFF); chk("in_3fff_not_lane", O, 8'hA3);

        step(1'b0, 16'h0000); chk("pre_pulse", O, 8'hAC);
        step(1'b0, 16'h0000); chk("hold_0000", O, 8'hAC);
        step(1'b1, 16'h0000); chk("mid_reset", O, 8'h00);
        step(1'b0, 16'h0000); chk("after_mid_reset", O, 8'hAC);

        for (int i = 0; i < 200; i++) begin
            rin  = 16'($urandom);
            rrst = ($urandom_range(0, 15) == 0);
            step(rrst, rin);
            chk("random", O, rrst ? 8'h00 : model(rin));
            if (!rrst) begin
                step(1'b0, rin ^ 16'h8000);
                chk("random_in15", O, model(rin));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end
endmodule
